// File: rtl/alu_seq_pkg.sv
// Shared constants, op codes, FSM states and response payload for the two-pass 32-bit ALU.
package alu_seq_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned HALF_W = 16;
    localparam int unsigned OP_W   = 3;

    localparam logic [OP_W-1:0] OP_AND = 3'd0;
    localparam logic [OP_W-1:0] OP_OR  = 3'd1;
    localparam logic [OP_W-1:0] OP_ADD = 3'd2;
    localparam logic [OP_W-1:0] OP_XOR = 3'd3;
    localparam logic [OP_W-1:0] OP_NOR = 3'd4;
    localparam logic [OP_W-1:0] OP_ILL = 3'd5;
    localparam logic [OP_W-1:0] OP_SUB = 3'd6;
    localparam logic [OP_W-1:0] OP_SLT = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              carry;
        logic              overflow;
        logic              zero;
        logic              illegal;
    } alu_resp_t;

    // SUB and SLT both run the adder as a + ~b + 1
    function automatic logic is_sub(input logic [OP_W-1:0] op);
        return (op == OP_SUB) || (op == OP_SLT);
    endfunction

endpackage

// File: rtl/cla_16.sv
// 16-bit carry-lookahead slice: sum/carry plus bitwise AND/OR/XOR/NOR of the same operands.
module cla_16
    import alu_seq_pkg::*;
(
    input  logic [HALF_W-1:0] a,
    input  logic [HALF_W-1:0] b,
    input  logic              cin,
    output logic [HALF_W-1:0] sum_c,
    output logic [HALF_W-1:0] and_c,
    output logic [HALF_W-1:0] or_c,
    output logic [HALF_W-1:0] xor_c,
    output logic [HALF_W-1:0] nor_c,
    output logic              cout_c
);

    localparam int unsigned GRP_W = 4;
    localparam int unsigned N_GRP = HALF_W / GRP_W;

    logic [HALF_W-1:0] g;
    logic [HALF_W-1:0] p;
    logic [HALF_W-1:0] c;
    logic [N_GRP-1:0]  grp_g;
    logic [N_GRP-1:0]  grp_p;
    logic [N_GRP:0]    grp_c;

    assign g = a & b;
    assign p = a ^ b;

    // Group generate/propagate, group carries, then per-bit carries inside each group
    always_comb begin
        grp_g = '0;
        grp_p = '0;
        grp_c = '0;
        c     = '0;
        for (int k = 0; k < N_GRP; k++) begin
            grp_g[k] = g[4*k+3]
                     | (p[4*k+3] & g[4*k+2])
                     | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            grp_p[k] = &p[4*k +: 4];
        end
        grp_c[0] = cin;
        for (int k = 0; k < N_GRP; k++) begin
            grp_c[k+1] = grp_g[k] | (grp_p[k] & grp_c[k]);
        end
        for (int k = 0; k < N_GRP; k++) begin
            c[4*k]   = grp_c[k];
            c[4*k+1] = g[4*k]   | (p[4*k]   & grp_c[k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
                     | (p[4*k+1] & p[4*k] & grp_c[k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                     | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & grp_c[k]);
        end
    end

    assign sum_c  = p ^ c;
    assign cout_c = grp_c[N_GRP];
    assign and_c  = g;
    assign or_c   = a | b;
    assign xor_c  = p;
    assign nor_c  = ~(a | b);

endmodule

// File: rtl/alu_seq32.sv
// 32-bit ALU that time-shares one 16-bit CLA slice: low half in LO, high half in HI.
module alu_seq32
    import alu_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              overflow,
    output logic              zero,
    output logic              illegal
);

    state_e            state_q, state_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [HALF_W-1:0] lo_res_q, lo_res_d;
    logic              lo_carry_q, lo_carry_d;
    alu_resp_t         resp_q, resp_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;

    logic              sub_c;
    logic [DATA_W-1:0] b_eff_c;
    logic [HALF_W-1:0] slice_a_c;
    logic [HALF_W-1:0] slice_b_c;
    logic              slice_cin_c;
    logic [HALF_W-1:0] sum_c, and_c, or_c, xor_c, nor_c;
    logic              cout_c;
    logic [HALF_W-1:0] half_res_c;
    logic              ovf_c;
    logic [DATA_W-1:0] full_res_c;

    assign sub_c       = is_sub(op_q);
    assign b_eff_c     = sub_c ? ~b_q : b_q;
    assign slice_a_c   = (state_q == ST_HI) ? a_q[DATA_W-1:HALF_W]     : a_q[HALF_W-1:0];
    assign slice_b_c   = (state_q == ST_HI) ? b_eff_c[DATA_W-1:HALF_W] : b_eff_c[HALF_W-1:0];
    assign slice_cin_c = (state_q == ST_HI) ? lo_carry_q : sub_c;

    cla_16 u_slice (
        .a      (slice_a_c),
        .b      (slice_b_c),
        .cin    (slice_cin_c),
        .sum_c  (sum_c),
        .and_c  (and_c),
        .or_c   (or_c),
        .xor_c  (xor_c),
        .nor_c  (nor_c),
        .cout_c (cout_c)
    );

    // Per-op selection of the slice output for the half currently in flight
    always_comb begin
        half_res_c = '0;
        case (op_q)
            OP_AND:                 half_res_c = and_c;
            OP_OR:                  half_res_c = or_c;
            OP_XOR:                 half_res_c = xor_c;
            OP_NOR:                 half_res_c = nor_c;
            OP_ADD, OP_SUB, OP_SLT: half_res_c = sum_c;
            default:                half_res_c = '0;
        endcase
    end

    // Only meaningful in HI, where the slice sum bit 15 is result bit 31
    assign ovf_c      = (a_q[DATA_W-1] == b_eff_c[DATA_W-1]) && (sum_c[HALF_W-1] != a_q[DATA_W-1]);
    assign full_res_c = {half_res_c, lo_res_q};

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        lo_res_d   = lo_res_q;
        lo_carry_d = lo_carry_q;
        resp_d     = resp_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_LO;
                    op_d    = op;
                    a_d     = a;
                    b_d     = b;
                end
            end
            ST_LO: begin
                state_d    = ST_HI;
                lo_res_d   = half_res_c;
                lo_carry_d = cout_c;
            end
            ST_HI: begin
                state_d = ST_DONE;
                resp_d  = '0;
                case (op_q)
                    OP_ADD, OP_SUB: begin
                        resp_d.result   = full_res_c;
                        resp_d.carry    = cout_c;
                        resp_d.overflow = ovf_c;
                    end
                    OP_SLT:  resp_d.result  = {(DATA_W-1)'(0), sum_c[HALF_W-1] ^ ovf_c};
                    OP_ILL:  resp_d.illegal = 1'b1;
                    default: resp_d.result  = full_res_c;
                endcase
                resp_d.zero = (resp_d.result == '0);
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            lo_res_q    <= '0;
            lo_carry_q  <= 1'b0;
            resp_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            lo_res_q    <= lo_res_d;
            lo_carry_q  <= lo_carry_d;
            resp_q      <= resp_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = resp_q.result;
    assign carry     = resp_q.carry;
    assign overflow  = resp_q.overflow;
    assign zero      = resp_q.zero;
    assign illegal   = resp_q.illegal;

endmodule

// File: tb/tb_alu_seq32.sv
// Directed-vector bench for alu_seq32 with hand-computed expected results.
module tb_alu_seq32;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        carry;
    logic        overflow;
    logic        zero;
    logic        illegal;

    int n_vec  = 0;
    int n_miss = 0;

    alu_seq32 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .overflow  (overflow),
        .zero      (zero),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Run one operation; inputs change and outputs are sampled on the falling edge.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] va,
                          input logic [31:0] vb, input logic [31:0] e_res, input logic e_c,
                          input logic e_v, input logic e_z, input logic e_ill, input int hold);
        @(negedge clk);
        chk({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        op = o;
        a  = va;
        b  = vb;
        @(negedge clk);  // LO: present junk that must be ignored, poke out_ready
        op = 3'd1;
        a  = 32'hDEAD_BEEF;
        b  = 32'hCAFE_F00D;
        out_ready = 1'b1;
        chk({tag, ".lo_ready"}, 32'(in_ready), 32'd0);
        chk({tag, ".lo_valid"}, 32'(out_valid), 32'd0);
        @(negedge clk);  // HI
        chk({tag, ".hi_valid"}, 32'(out_valid), 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);  // DONE: cycle n+3
        chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".result"}, result, e_res);
        chk({tag, ".flags"}, {28'd0, carry, overflow, zero, illegal}, {28'd0, e_c, e_v, e_z, e_ill});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, ".hold_ready"}, 32'(in_ready), 32'd0);
            chk({tag, ".hold_result"}, result, e_res);
            chk({tag, ".hold_flags"}, {28'd0, carry, overflow, zero, illegal},
                {28'd0, e_c, e_v, e_z, e_ill});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, ".drain_valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".drain_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = 3'd0;
        a         = '0;
        b         = '0;
        repeat (2) @(negedge clk);
        chk("reset.in_ready", 32'(in_ready), 32'd1);
        chk("reset.out_valid", 32'(out_valid), 32'd0);
        chk("reset.result", result, 32'd0);
        chk("reset.flags", {28'd0, carry, overflow, zero, illegal}, 32'd0);
        rst = 1'b0;

        run_op("add",  3'd2, 32'h0000_FFFF, 32'h0000_0001, 32'h0001_0000, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        run_op("sub",  3'd6, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        run_op("slt",  3'd7, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        run_op("xor",  3'd3, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0, 1'b0, 1'b0, 1'b0, 5);
        run_op("ill",  3'd5, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b1, 0);
        run_op("and",  3'd0, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        run_op("or",   3'd1, 32'hF000_000F, 32'h0F00_00F0, 32'hFF00_00FF, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        run_op("nor",  3'd4, 32'hFFFF_0000, 32'h0000_FF00, 32'h0000_00FF, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        run_op("subz", 3'd6, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 0);
        run_op("sltn", 3'd7, 32'h0000_0005, 32'hFFFF_FFFD, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        run_op("addc", 3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        run_op("addv", 3'd2, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 0);

        // Reset while in HI must abandon the operation
        @(negedge clk);
        in_valid = 1'b1;
        op = 3'd2;
        a  = 32'hFFFF_FFFF;
        b  = 32'h0000_0001;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b0;
        chk("rst_hi.in_ready", 32'(in_ready), 32'd1);
        chk("rst_hi.out_valid", 32'(out_valid), 32'd0);
        chk("rst_hi.result", result, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_hi.no_valid", 32'(out_valid), 32'd0);
        end

        run_op("post", 3'd2, 32'h0000_0003, 32'h0000_0004, 32'h0000_0007, 1'b0, 1'b0, 1'b0, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/alu_seq32.md
ALU_SEQ32 -- requirements
Module: alu_seq32

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: in_valid  input  1  requester presents an operation.
REQ-004 SHALL have port: in_ready  output  1  block accepts an operation this cycle.
REQ-005 SHALL have port: op  input  3  operation code: 0 AND, 1 OR, 2 ADD, 3 XOR, 4 NOR, 6 SUB, 7 SLT; 5 illegal.
REQ-006 SHALL have port: a  input  32  operand A.
REQ-007 SHALL have port: b  input  32  operand B.
REQ-008 SHALL have port: out_valid  output  1  result fields are valid.
REQ-009 SHALL have port: out_ready  input  1  consumer takes the result.
REQ-010 SHALL have port: result  output  32  operation result.
REQ-011 SHALL have port: carry  output  1  carry out of bit 31 (ADD/SUB only, else 0).
REQ-012 SHALL have port: overflow  output  1  signed overflow (ADD/SUB only, else 0).
REQ-013 SHALL have port: zero  output  1  result == 0.
REQ-014 SHALL have port: illegal  output  1  op was code 5.

Function
REQ-015 SHALL time-share one 16-bit slice (sum, AND/OR/XOR/NOR, carry in/out) over two cycles per 32-bit operation: low half, then high half.
REQ-016 SHALL implement FSM states IDLE, LO, HI, DONE; IDLE->LO on in_valid&&in_ready; LO->HI always; HI->DONE always; DONE->IDLE on out_ready.
REQ-017 SHALL assert in_ready only in IDLE; op, a, b are latched on the accepting edge and the inputs are ignored afterwards.
REQ-018 LO: slice gets a[15:0], b'[15:0], Cin = 1 for SUB/SLT and 0 otherwise; b' = ~b for SUB/SLT and b otherwise; low result and slice carry are registered.
REQ-019 HI: slice gets a[31:16], b'[31:16], Cin = registered low carry; high result and carry out are registered.
REQ-020 Latency: handshake in cycle n; out_valid high from cycle n+3; minimum spacing between accepts is 4 cycles.
REQ-021 SHALL hold out_valid, result, carry, overflow, zero and illegal stable in DONE until out_ready is sampled high.
REQ-022 overflow = (a[31] == b'[31]) && (sum[31] != a[31]) for ADD/SUB.
REQ-023 SLT: result = {31'b0, sum[31] ^ ovf}, where sum and ovf are the SUB values; carry = overflow = 0.
REQ-024 Logic ops: carry = overflow = 0; slice logic outputs are concatenated high:low.
REQ-025 Illegal op: result = 0, illegal = 1, zero = 1, carry = overflow = 0; the FSM still passes through all states with normal latency.
REQ-026 in_valid in any non-IDLE state SHALL be ignored, with no queuing.
REQ-027 out_ready outside DONE SHALL have no effect.

Reset
REQ-028 rst high at a clock edge SHALL force IDLE and clear the output registers, giving in_ready = 1 and out_valid = result = carry = overflow = zero = illegal = 0.
REQ-029 Reset mid-operation (LO/HI/DONE) SHALL discard the operation; no out_valid follows.
REQ-030 rst SHALL take priority over any simultaneous handshake.

Structure
REQ-031 Shared package alu_seq_pkg SHALL hold the op-code constants, the FSM state enum, and the width constants (32 and 16).
REQ-032 The single sub-module SHALL be the team's existing 16-bit carry-lookahead slice cla_16, instantiated once.
REQ-033 Target size: 120-400 RTL lines; no combinational path from in_valid to out_valid.

Verification
REQ-034 ADD: a = 0x0000FFFF, b = 0x00000001 -> result 0x00010000, carry 0, overflow 0, out_valid exactly 3 cycles after handshake.
REQ-035 SUB/overflow: a = 0x80000000, b = 0x00000001 SUB -> result 0x7FFFFFFF, overflow 1, carry 1; SLT with the same operands -> result 1.
REQ-036 Backpressure: XOR 0xFFFF0000 ^ 0x0F0F0F0F -> 0xF0F00F0F; hold out_ready = 0 for 5 cycles -> outputs stable and in_ready 0 throughout.
REQ-037 Reset in HI during ADD 0xFFFFFFFF + 1 -> next cycle IDLE, in_ready 1, out_valid never rises.
REQ-038 Illegal op 5 with a = b = 0x12345678 -> result 0, illegal 1, zero 1; a following AND 0xFF00FF00 & 0x0FF00FF0 -> 0x0F000F00, illegal 0.
